// File: rtl/isp1362_bus_sequencer_pkg.sv
// Shared types and timing defaults for the ISP1362 host-port sequencer.
package isp1362_bus_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned NREQ   = 2;

    localparam int unsigned SETUP_CYC_DEF   = 1;
    localparam int unsigned STROBE_CYC_DEF  = 3;
    localparam int unsigned HOLD_CYC_DEF    = 1;
    localparam int unsigned RECOVER_CYC_DEF = 4;
    localparam int unsigned CMD_GAP_CYC_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } state_e;

    // Access latched at grant time
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    // Width of a down-counter able to hold the largest phase length
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d,
                                              input int unsigned e);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/isp1362_bus_sequencer_if.sv
// Requester-side and pin-side signals of the ISP1362 host-port sequencer.
interface isp1362_bus_sequencer_if;
    import isp1362_bus_pkg::*;

    logic [NREQ-1:0]   iREQ;
    logic [NREQ-1:0]   iWR;
    logic [ADDR_W-1:0] iADDR0;
    logic [ADDR_W-1:0] iADDR1;
    logic [DATA_W-1:0] iWDATA0;
    logic [DATA_W-1:0] iWDATA1;
    logic [NREQ-1:0]   oACK;
    logic [DATA_W-1:0] oRDATA;
    logic              oBUSY;
    logic [ADDR_W-1:0] oOTG_ADDR;
    logic              oOTG_CS_N;
    logic              oOTG_RD_N;
    logic              oOTG_WR_N;
    logic [DATA_W-1:0] oOTG_DOUT;
    logic              oOTG_DOE;
    logic [DATA_W-1:0] iOTG_DIN;

    modport slave (
        input  iREQ, iWR, iADDR0, iADDR1, iWDATA0, iWDATA1, iOTG_DIN,
        output oACK, oRDATA, oBUSY, oOTG_ADDR, oOTG_CS_N, oOTG_RD_N, oOTG_WR_N,
               oOTG_DOUT, oOTG_DOE
    );

    modport master (
        output iREQ, iWR, iADDR0, iADDR1, iWDATA0, iWDATA1, iOTG_DIN,
        input  oACK, oRDATA, oBUSY, oOTG_ADDR, oOTG_CS_N, oOTG_RD_N, oOTG_WR_N,
               oOTG_DOUT, oOTG_DOE
    );

endinterface

// File: rtl/isp1362_bus_sequencer_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last requester served.
module isp1362_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic       o_gnt_c
);

    logic r_last;

    // Contention goes to whoever was not served last
    always_comb begin
        o_gnt_c = i_req[1];
        if (i_req == 2'b11) o_gnt_c = ~r_last;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)       r_last <= 1'b1;
        else if (i_take) r_last <= o_gnt_c;
    end

endmodule

// File: rtl/isp1362_bus_sequencer.sv
// ISP1362 host-port sequencer: arbitrates two requesters and times CS_N/RD_N/WR_N.
// ISP1362_CMD_GAP_EN: stretch recovery to CMD_GAP_CYC after command-port writes.
module isp1362_bus_sequencer
    import isp1362_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = SETUP_CYC_DEF,
    parameter int unsigned STROBE_CYC  = STROBE_CYC_DEF,
    parameter int unsigned HOLD_CYC    = HOLD_CYC_DEF,
    parameter int unsigned RECOVER_CYC = RECOVER_CYC_DEF,
    parameter int unsigned CMD_GAP_CYC = CMD_GAP_CYC_DEF
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    isp1362_bus_sequencer_if.slave   bus
);

    localparam int unsigned CNT_W =
        cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC, RECOVER_CYC, CMD_GAP_CYC);

    state_e            r_state, w_state_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx, w_rec_len;
    acc_t              r_acc, w_acc_nx;
    logic              r_grant, w_grant_nx;
    logic              w_gnt, w_take;
    logic [NREQ-1:0]   r_ack, w_ack_nx;
    logic [DATA_W-1:0] r_rdata, w_rdata_nx;
    logic              r_busy, w_busy_nx;
    logic              r_cs_n, w_cs_n_nx;
    logic              r_rd_n, w_rd_n_nx;
    logic              r_wr_n, w_wr_n_nx;
    logic              r_doe, w_doe_nx;

    isp1362_rr_arb2 u_arb (
        .i_clk   (iCLK),
        .i_rst   (iRST),
        .i_req   (bus.iREQ),
        .i_take  (w_take),
        .o_gnt_c (w_gnt)
    );

    // Recovery length depends on whether the access just finished was a command write
    always_comb begin
`ifdef ISP1362_CMD_GAP_EN
        w_rec_len = (r_acc.wr && r_acc.addr[0]) ? CNT_W'(CMD_GAP_CYC - 1)
                                                : CNT_W'(RECOVER_CYC - 1);
`else
        w_rec_len = CNT_W'(RECOVER_CYC - 1);
`endif
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
        w_acc_nx   = r_acc;
        w_grant_nx = r_grant;
        w_take     = 1'b0;
        w_ack_nx   = '0;
        w_rdata_nx = r_rdata;
        w_busy_nx  = r_busy;
        w_cs_n_nx  = r_cs_n;
        w_rd_n_nx  = r_rd_n;
        w_wr_n_nx  = r_wr_n;
        w_doe_nx   = r_doe;

        case (r_state)
            ST_IDLE: begin
                if (bus.iREQ != '0) begin
                    w_take         = 1'b1;
                    w_grant_nx     = w_gnt;
                    w_acc_nx.wr    = w_gnt ? bus.iWR[1] : bus.iWR[0];
                    w_acc_nx.addr  = w_gnt ? bus.iADDR1 : bus.iADDR0;
                    w_acc_nx.wdata = w_gnt ? bus.iWDATA1 : bus.iWDATA0;
                    w_doe_nx       = w_acc_nx.wr;
                    w_cs_n_nx      = 1'b0;
                    w_busy_nx      = 1'b1;
                    w_cnt_nx       = CNT_W'(SETUP_CYC - 1);
                    w_state_nx     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_rd_n_nx  = r_acc.wr;
                    w_wr_n_nx  = ~r_acc.wr;
                    w_cnt_nx   = CNT_W'(STROBE_CYC - 1);
                    w_state_nx = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (r_cnt == '0) begin
                    if (!r_acc.wr) w_rdata_nx = bus.iOTG_DIN;
                    w_rd_n_nx  = 1'b1;
                    w_wr_n_nx  = 1'b1;
                    w_cnt_nx   = CNT_W'(HOLD_CYC - 1);
                    w_state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_cs_n_nx  = 1'b1;
                    w_doe_nx   = 1'b0;
                    w_cnt_nx   = w_rec_len;
                    w_state_nx = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (r_cnt == '0) begin
                    w_busy_nx  = 1'b0;
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_cs_n_nx  = 1'b1;
                w_rd_n_nx  = 1'b1;
                w_wr_n_nx  = 1'b1;
                w_doe_nx   = 1'b0;
                w_busy_nx  = 1'b0;
                w_state_nx = ST_IDLE;
            end
        endcase

        // Ack is registered so it lands exactly on the final HOLD cycle
        if (w_state_nx == ST_HOLD && w_cnt_nx == '0)
            w_ack_nx = r_grant ? 2'b10 : 2'b01;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_grant <= 1'b0;
            r_ack   <= '0;
            r_rdata <= '0;
            r_busy  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_doe   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_acc   <= w_acc_nx;
            r_grant <= w_grant_nx;
            r_ack   <= w_ack_nx;
            r_rdata <= w_rdata_nx;
            r_busy  <= w_busy_nx;
            r_cs_n  <= w_cs_n_nx;
            r_rd_n  <= w_rd_n_nx;
            r_wr_n  <= w_wr_n_nx;
            r_doe   <= w_doe_nx;
        end
    end

    assign bus.oACK      = r_ack;
    assign bus.oRDATA    = r_rdata;
    assign bus.oBUSY     = r_busy;
    assign bus.oOTG_ADDR = r_acc.addr;
    assign bus.oOTG_CS_N = r_cs_n;
    assign bus.oOTG_RD_N = r_rd_n;
    assign bus.oOTG_WR_N = r_wr_n;
    assign bus.oOTG_DOUT = r_acc.wdata;
    assign bus.oOTG_DOE  = r_doe;

endmodule

// File: tb/tb_isp1362_bus_sequencer.sv
// Bench for isp1362_bus_sequencer: directed scenarios plus randomized accesses vs. a timing model.
module tb_isp1362_bus_sequencer;

    localparam int S = 1, P = 3, H = 1, R = 4, G = 8;
    localparam int LAT    = 1 + S + P + H;
    localparam int CS_LEN = S + P + H;
`ifdef ISP1362_CMD_GAP_EN
    localparam int GAP_EXP = G;
`else
    localparam int GAP_EXP = R;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic        model_last = 1'b1;
    logic [15:0] exp_rdata  = '0;

    isp1362_bus_sequencer_if b();

    isp1362_bus_sequencer dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (b.slave)
    );

    always #5 clk = ~clk;

    task automatic start_req(input logic [1:0] req, input logic [1:0] wr,
                             input logic [1:0] a0, input logic [1:0] a1,
                             input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] din);
        @(posedge clk); #1;
        b.iWR = wr; b.iADDR0 = a0; b.iADDR1 = a1;
        b.iWDATA0 = d0; b.iWDATA1 = d1; b.iOTG_DIN = din;
        b.iREQ = req;
    endtask

    // Observes one access pin-by-pin, cycle 1 being the cycle the request is sampled in
    task automatic measure(input int start, input logic drop_ack, input logic drop_setup,
                           input logic exp_doe, input logic [15:0] exp_dout,
                           input logic [1:0] exp_addr,
                           output int ack_cyc, output logic [1:0] ack_val, output int ack_cnt,
                           output logic [15:0] rd_at_ack, output int cs_lo, output int rd_lo,
                           output int wr_lo, output int rec, output int pin_bad,
                           output logic tmo);
        int   cyc;
        logic done;
        cyc = start; done = 1'b0; tmo = 1'b1;
        ack_cyc = 0; ack_val = '0; ack_cnt = 0; rd_at_ack = '0;
        cs_lo = 0; rd_lo = 0; wr_lo = 0; rec = 0; pin_bad = 0;
        for (int k = 0; k < 80 && !done; k++) begin
            @(negedge clk);
            cyc++;
            if (!b.oOTG_CS_N) begin
                cs_lo++;
                if (b.oOTG_DOE !== exp_doe || b.oOTG_ADDR !== exp_addr ||
                    (exp_doe && b.oOTG_DOUT !== exp_dout)) pin_bad++;
                if (drop_setup) b.iREQ = '0;
            end else if (b.oOTG_DOE !== 1'b0 || !b.oOTG_RD_N || !b.oOTG_WR_N) pin_bad++;
            if (!b.oOTG_RD_N) rd_lo++;
            if (!b.oOTG_WR_N) wr_lo++;
            if (b.oACK != '0) begin
                ack_cnt++;
                if (ack_cyc == 0) begin
                    ack_cyc = cyc; ack_val = b.oACK; rd_at_ack = b.oRDATA;
                end
                if (drop_ack) b.iREQ = '0;
            end
            if (ack_cyc != 0 && b.oOTG_CS_N && b.oBUSY) rec++;
            if (ack_cyc != 0 && !b.oBUSY) begin done = 1'b1; tmo = 1'b0; end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; b.iREQ = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_last = 1'b1; exp_rdata = '0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (b.oACK !== 2'b00) begin bad++; $display("FAIL rst_ack got=%0h exp=0", b.oACK); end
        total++; if (b.oRDATA !== 16'h0) begin bad++; $display("FAIL rst_rdata got=%0h exp=0", b.oRDATA); end
        total++; if (b.oBUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", b.oBUSY); end
        total++; if (b.oOTG_ADDR !== 2'b00) begin bad++; $display("FAIL rst_addr got=%0h exp=0", b.oOTG_ADDR); end
        total++; if ({b.oOTG_CS_N, b.oOTG_RD_N, b.oOTG_WR_N} !== 3'b111) begin bad++; $display("FAIL rst_strobes got=%b exp=111", {b.oOTG_CS_N, b.oOTG_RD_N, b.oOTG_WR_N}); end
        total++; if (b.oOTG_DOUT !== 16'h0) begin bad++; $display("FAIL rst_dout got=%0h exp=0", b.oOTG_DOUT); end
        total++; if (b.oOTG_DOE !== 1'b0) begin bad++; $display("FAIL rst_doe got=%0b exp=0", b.oOTG_DOE); end
        @(posedge clk); #1 rst = 1'b0;
        model_last = 1'b1; exp_rdata = '0;
    endtask

    task automatic test_read();
        int ac, acn, cl, rl, wl, rc, pb; logic [1:0] av; logic [15:0] rd; logic to;
        start_req(2'b01, 2'b00, 2'd2, 2'd0, 16'h0, 16'h0, 16'hA5C3);
        measure(0, 1'b1, 1'b0, 1'b0, 16'h0, 2'd2, ac, av, acn, rd, cl, rl, wl, rc, pb, to);
        model_last = 1'b0; exp_rdata = 16'hA5C3;
        total++; if (to !== 1'b0) begin bad++; $display("FAIL read_timeout got=%0b exp=0", to); end
        total++; if (cl != CS_LEN) begin bad++; $display("FAIL read_cs_low got=%0d exp=%0d", cl, CS_LEN); end
        total++; if (rl != P || wl != 0) begin bad++; $display("FAIL read_strobe got=rd%0d/wr%0d exp=rd%0d/wr0", rl, wl, P); end
        total++; if (ac != LAT) begin bad++; $display("FAIL read_latency got=%0d exp=%0d", ac, LAT); end
        total++; if (av !== 2'b01 || acn != 1) begin bad++; $display("FAIL read_ack got=%b x%0d exp=01 x1", av, acn); end
        total++; if (rd !== exp_rdata) begin bad++; $display("FAIL read_rdata got=%0h exp=%0h", rd, exp_rdata); end
        total++; if (pb != 0) begin bad++; $display("FAIL read_pins got=%0d exp=0", pb); end
        total++; if (rc != R) begin bad++; $display("FAIL read_recover got=%0d exp=%0d", rc, R); end
    endtask

    task automatic test_write();
        int ac, acn, cl, rl, wl, rc, pb; logic [1:0] av; logic [15:0] rd; logic to;
        start_req(2'b10, 2'b10, 2'd0, 2'd0, 16'h0, 16'h1234, 16'hFFFF);
        measure(0, 1'b1, 1'b0, 1'b1, 16'h1234, 2'd0, ac, av, acn, rd, cl, rl, wl, rc, pb, to);
        model_last = 1'b1;
        total++; if (to !== 1'b0) begin bad++; $display("FAIL write_timeout got=%0b exp=0", to); end
        total++; if (wl != P || rl != 0) begin bad++; $display("FAIL write_strobe got=wr%0d/rd%0d exp=wr%0d/rd0", wl, rl, P); end
        total++; if (pb != 0) begin bad++; $display("FAIL write_doe_dout got=%0d bad cycles exp=0", pb); end
        total++; if (av !== 2'b10 || ac != LAT) begin bad++; $display("FAIL write_ack got=%b@%0d exp=10@%0d", av, ac, LAT); end
        total++; if (rd !== exp_rdata) begin bad++; $display("FAIL write_rdata_kept got=%0h exp=%0h", rd, exp_rdata); end
        total++; if (rc != R) begin bad++; $display("FAIL write_recover got=%0d exp=%0d", rc, R); end
    endtask

    task automatic test_back_to_back();
        int ac, acn, cl, rl, wl, rc, pb; logic [1:0] av; logic [15:0] rd; logic to;
        logic g; logic [15:0] din;
        do_reset();
        din = 16'($urandom);
        start_req(2'b11, 2'b00, 2'd2, 2'd3, 16'h0, 16'h0, din);
        exp_rdata = din;
        for (int n = 0; n < 4; n++) begin
            g = ~model_last; model_last = g;
            measure((n == 0) ? 0 : 1, (n == 3), 1'b0, 1'b0, 16'h0, g ? 2'd3 : 2'd2,
                    ac, av, acn, rd, cl, rl, wl, rc, pb, to);
            total++; if (to !== 1'b0) begin bad++; $display("FAIL b2b_timeout n=%0d got=%0b exp=0", n, to); end
            total++; if (av !== (g ? 2'b10 : 2'b01)) begin bad++; $display("FAIL b2b_grant n=%0d got=%b exp=%b", n, av, g ? 2'b10 : 2'b01); end
            total++; if (ac != LAT) begin bad++; $display("FAIL b2b_latency n=%0d got=%0d exp=%0d", n, ac, LAT); end
            total++; if (rc != R || pb != 0) begin bad++; $display("FAIL b2b_recover n=%0d got=%0d/pins%0d exp=%0d/pins0", n, rc, pb, R); end
        end
    endtask

    task automatic test_cmd_gap();
        int ac, acn, cl, rl, wl, rc, pb; logic [1:0] av; logic [15:0] rd; logic to;
        logic [15:0] d, din;
        d = 16'($urandom); din = 16'($urandom);
        start_req(2'b01, 2'b01, 2'd1, 2'd0, d, 16'h0, 16'h0);
        measure(0, 1'b1, 1'b0, 1'b1, d, 2'd1, ac, av, acn, rd, cl, rl, wl, rc, pb, to);
        model_last = 1'b0;
        total++; if (rc != GAP_EXP || to) begin bad++; $display("FAIL cmd_gap_write got=%0d exp=%0d", rc, GAP_EXP); end
        total++; if (pb != 0) begin bad++; $display("FAIL cmd_gap_pins got=%0d exp=0", pb); end
        start_req(2'b01, 2'b00, 2'd0, 2'd0, 16'h0, 16'h0, din);
        measure(0, 1'b1, 1'b0, 1'b0, 16'h0, 2'd0, ac, av, acn, rd, cl, rl, wl, rc, pb, to);
        exp_rdata = din;
        total++; if (rc != R || to) begin bad++; $display("FAIL cmd_gap_read got=%0d exp=%0d", rc, R); end
        total++; if (rd !== exp_rdata) begin bad++; $display("FAIL cmd_gap_rdata got=%0h exp=%0h", rd, exp_rdata); end
    endtask

    task automatic test_drop_in_setup();
        int ac, acn, cl, rl, wl, rc, pb; logic [1:0] av; logic [15:0] rd; logic to;
        logic [15:0] din;
        din = 16'($urandom);
        start_req(2'b01, 2'b00, 2'd2, 2'd0, 16'h0, 16'h0, din);
        measure(0, 1'b1, 1'b1, 1'b0, 16'h0, 2'd2, ac, av, acn, rd, cl, rl, wl, rc, pb, to);
        model_last = 1'b0; exp_rdata = din;
        total++; if (av !== 2'b01 || ac != LAT || to) begin bad++; $display("FAIL drop_setup_ack got=%b@%0d exp=01@%0d", av, ac, LAT); end
        total++; if (cl != CS_LEN || rl != P) begin bad++; $display("FAIL drop_setup_strobe got=cs%0d/rd%0d exp=cs%0d/rd%0d", cl, rl, CS_LEN, P); end
        total++; if (rd !== exp_rdata) begin bad++; $display("FAIL drop_setup_rdata got=%0h exp=%0h", rd, exp_rdata); end
    endtask

    task automatic test_mid_reset();
        int rl, acks; logic hit;
        rl = 0; acks = 0; hit = 1'b0;
        start_req(2'b01, 2'b00, 2'd1, 2'd0, 16'h0, 16'h0, 16'h5A5A);
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            if (!b.oOTG_RD_N) rl++;
            if (rl == 2) hit = 1'b1;
        end
        total++; if (!hit) begin bad++; $display("FAIL midrst_reach got=%0d strobe cycles exp=2", rl); end
        rst = 1'b1;
        @(negedge clk);
        total++; if ({b.oOTG_CS_N, b.oOTG_RD_N, b.oOTG_WR_N, b.oOTG_DOE} !== 4'b1110) begin bad++; $display("FAIL midrst_pins got=%b exp=1110", {b.oOTG_CS_N, b.oOTG_RD_N, b.oOTG_WR_N, b.oOTG_DOE}); end
        b.iREQ = '0;
        if (b.oACK != '0) acks++;
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1; exp_rdata = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (b.oACK != '0) acks++;
        end
        total++; if (acks != 0) begin bad++; $display("FAIL midrst_noack got=%0d exp=0", acks); end
        total++; if (b.oRDATA !== 16'h0 || b.oBUSY !== 1'b0) begin bad++; $display("FAIL midrst_state got=%0h/%0b exp=0/0", b.oRDATA, b.oBUSY); end
    endtask

    task automatic test_random();
        int ac, acn, cl, rl, wl, rc, pb; logic [1:0] av; logic [15:0] rd; logic to;
        logic [1:0] pat, wr, a0, a1, eaddr; logic [15:0] d0, d1, din, edout;
        logic g, ewr; int erec;
        for (int i = 0; i < 12; i++) begin
            pat = 2'($urandom_range(1, 3));
            wr = 2'($urandom); a0 = 2'($urandom); a1 = 2'($urandom);
            d0 = 16'($urandom); d1 = 16'($urandom); din = 16'($urandom);
            g = (pat == 2'b11) ? ~model_last : pat[1];
            model_last = g;
            ewr = g ? wr[1] : wr[0];
            eaddr = g ? a1 : a0;
            edout = g ? d1 : d0;
            if (!ewr) exp_rdata = din;
            erec = (ewr && eaddr[0]) ? GAP_EXP : R;
            start_req(pat, wr, a0, a1, d0, d1, din);
            measure(0, 1'b1, 1'b0, ewr, edout, eaddr, ac, av, acn, rd, cl, rl, wl, rc, pb, to);
            total++; if (to !== 1'b0) begin bad++; $display("FAIL rnd_timeout i=%0d got=%0b exp=0", i, to); end
            total++; if (av !== (g ? 2'b10 : 2'b01) || ac != LAT) begin bad++; $display("FAIL rnd_ack i=%0d got=%b@%0d exp=%b@%0d", i, av, ac, g ? 2'b10 : 2'b01, LAT); end
            total++; if (rd !== exp_rdata) begin bad++; $display("FAIL rnd_rdata i=%0d got=%0h exp=%0h", i, rd, exp_rdata); end
            total++; if ((ewr ? wl : rl) != P || cl != CS_LEN) begin bad++; $display("FAIL rnd_strobe i=%0d got=%0d/cs%0d exp=%0d/cs%0d", i, ewr ? wl : rl, cl, P, CS_LEN); end
            total++; if (pb != 0) begin bad++; $display("FAIL rnd_pins i=%0d got=%0d exp=0", i, pb); end
            total++; if (rc != erec) begin bad++; $display("FAIL rnd_recover i=%0d got=%0d exp=%0d", i, rc, erec); end
        end
    endtask

    initial begin
        b.iREQ = '0; b.iWR = '0; b.iADDR0 = '0; b.iADDR1 = '0;
        b.iWDATA0 = '0; b.iWDATA1 = '0; b.iOTG_DIN = '0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_cmd_gap();
        test_drop_in_setup();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
